// File: rtl/qspi_target_mem.sv
// qspi_target_mem: QSPI mode-0 target backed by a 2^ADDR_BITS byte register memory.
// sck/csn/io_i are oversampled on `clock` through 2-flop synchronizers.
// Commands: 0x02 single write, 0x03 single read, 0x32 quad write, 0x6B quad read.
// Optional feature macro: QSPI_TARGET_MEM_QUAD_EN enables 0x32/0x6B and the DUMMY phase;
// without it those commands are treated as unknown and only io[1] is ever driven.
`timescale 1ns/1ps

module qspi_target_mem #(
    parameter int ADDR_BITS    = 4,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 csn,
    input  logic [3:0]           io_i,
    output logic [3:0]           io_o,
    output logic [3:0]           io_oe,
    output logic                 wr_valid,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    localparam int                   DEPTH      = 1 << ADDR_BITS;
    localparam logic [7:0]           DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] ONE_A      = ADDR_BITS'(1);

    // synchronizer and edge-history flops
    logic                 r_sck_s1, r_sck_s2, r_sck_d;
    logic                 r_csn_s1, r_csn_s2, r_csn_d;
    logic [3:0]           r_io_s1, r_io_s2;

    // transaction state
    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [6:0]           r_cmd;
    logic                 r_rd;
    logic                 r_quad;
    logic [ADDR_BITS-1:0] r_addr;
    logic [7:0]           r_shift;
    logic [3:0]           r_ob;
    logic [7:0]           r_mem [DEPTH];

    // registered outputs
    logic [3:0]           r_io_o;
    logic [3:0]           r_io_oe;
    logic                 r_wr_valid;
    logic [ADDR_BITS-1:0] r_wr_addr;
    logic [7:0]           r_wr_data;

    logic                 w_sck_rise, w_sck_fall, w_csn_fall;
    logic                 w_bit;
    logic [7:0]           w_cmd;
    logic                 w_cmd_ok, w_cmd_rd, w_cmd_qd;
    logic [ADDR_BITS-1:0] w_addr_shift;
    logic [7:0]           w_wbyte;
    logic                 w_byte_last;

    // Two-flop synchronizers; csn history resets low so a csn already low at reset
    // release is not mistaken for a fresh falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
            r_csn_s1 <= 1'b0;
            r_csn_s2 <= 1'b0;
            r_csn_d  <= 1'b0;
            r_io_s1  <= 4'b0;
            r_io_s2  <= 4'b0;
        end else begin
            r_sck_s1 <= sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
            r_csn_s1 <= csn;
            r_csn_s2 <= r_csn_s1;
            r_csn_d  <= r_csn_s2;
            r_io_s1  <= io_i;
            r_io_s2  <= r_io_s1;
        end
    end

    assign w_sck_rise   = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall   = ~r_sck_s2 & r_sck_d;
    assign w_csn_fall   = ~r_csn_s2 & r_csn_d;
    assign w_bit        = r_io_s2[0];
    assign w_cmd        = {r_cmd, w_bit};
    assign w_addr_shift = {r_addr[ADDR_BITS-2:0], w_bit};
    assign w_wbyte      = r_quad ? {r_shift[3:0], r_io_s2} : {r_shift[6:0], w_bit};
    assign w_byte_last  = r_quad ? (r_cnt == 8'd1) : (r_cnt == 8'd7);

    // Command decode of the byte completing on this rising edge.
    always_comb begin
        w_cmd_ok = 1'b0;
        w_cmd_rd = 1'b0;
        w_cmd_qd = 1'b0;
        case (w_cmd)
            8'h02: w_cmd_ok = 1'b1;
            8'h03: begin
                w_cmd_ok = 1'b1;
                w_cmd_rd = 1'b1;
            end
`ifdef QSPI_TARGET_MEM_QUAD_EN
            8'h32: begin
                w_cmd_ok = 1'b1;
                w_cmd_qd = 1'b1;
            end
            8'h6B: begin
                w_cmd_ok = 1'b1;
                w_cmd_rd = 1'b1;
                w_cmd_qd = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Protocol FSM, memory and registered pin outputs; a high csn overrides any sck edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_cmd      <= 7'd0;
            r_rd       <= 1'b0;
            r_quad     <= 1'b0;
            r_addr     <= '0;
            r_shift    <= 8'd0;
            r_ob       <= 4'b0;
            r_io_o     <= 4'b0;
            r_io_oe    <= 4'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            r_wr_valid <= 1'b0;
            // pins lag the falling-edge shift by one cycle
            r_io_o     <= (r_state == S_RDATA) ? r_ob : 4'b0;
`ifdef QSPI_TARGET_MEM_QUAD_EN
            r_io_oe    <= (r_state == S_RDATA) ? (r_quad ? 4'b1111 : 4'b0010) : 4'b0000;
`else
            r_io_oe    <= (r_state == S_RDATA) ? 4'b0010 : 4'b0000;
`endif
            if (r_csn_s2) begin
                r_state <= S_IDLE;
                r_cnt   <= 8'd0;
                r_ob    <= 4'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_csn_fall) begin
                            r_state <= S_CMD;
                            r_cnt   <= 8'd0;
                        end
                    end
                    S_CMD: begin
                        if (w_sck_rise) begin
                            r_cmd <= {r_cmd[5:0], w_bit};
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == 8'd7) begin
                                r_cnt   <= 8'd0;
                                r_rd    <= w_cmd_rd;
                                r_quad  <= w_cmd_qd;
                                r_state <= w_cmd_ok ? S_ADDR : S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sck_rise) begin
                            // upper address bits simply shift out of r_addr
                            r_addr <= w_addr_shift;
                            r_cnt  <= r_cnt + 8'd1;
                            if (r_cnt == 8'd7) begin
                                r_cnt <= 8'd0;
                                if (!r_rd) begin
                                    r_state <= S_WDATA;
                                end else if (r_quad) begin
                                    r_state <= S_DUMMY;
                                end else begin
                                    r_state <= S_RDATA;
                                    r_shift <= r_mem[w_addr_shift];
                                    r_addr  <= w_addr_shift + ONE_A;
                                    r_ob    <= 4'b0;
                                end
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_sck_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == DUMMY_LAST) begin
                                r_cnt   <= 8'd0;
                                r_state <= S_RDATA;
                                r_shift <= r_mem[r_addr];
                                r_addr  <= r_addr + ONE_A;
                                r_ob    <= 4'b0;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_sck_rise) begin
                            r_shift <= w_wbyte;
                            r_cnt   <= r_cnt + 8'd1;
                            if (w_byte_last) begin
                                r_cnt         <= 8'd0;
                                r_mem[r_addr] <= w_wbyte;
                                r_wr_valid    <= 1'b1;
                                r_wr_addr     <= r_addr;
                                r_wr_data     <= w_wbyte;
                                r_addr        <= r_addr + ONE_A;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_sck_fall) begin
                            r_ob <= r_quad ? r_shift[7:4] : {2'b00, r_shift[7], 1'b0};
                            if (w_byte_last) begin
                                r_cnt   <= 8'd0;
                                r_shift <= r_mem[r_addr];
                                r_addr  <= r_addr + ONE_A;
                            end else begin
                                r_cnt   <= r_cnt + 8'd1;
                                r_shift <= r_quad ? {r_shift[3:0], 4'b0} : {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    S_IGNORE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign io_o     = r_io_o;
    assign io_oe    = r_io_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_qspi_target_mem.sv
// tb_qspi_target_mem: directed bench for qspi_target_mem acting as a mode-0 initiator.
// Expectations for quad commands follow QSPI_TARGET_MEM_QUAD_EN.
`timescale 1ns/1ps

module tb_qspi_target_mem;

    localparam int AB   = 4;
    localparam int DC   = 4;
    localparam int HALF = 8;   // clocks per sck phase
`ifdef QSPI_TARGET_MEM_QUAD_EN
    localparam bit QE = 1'b1;
`else
    localparam bit QE = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          sck;
    logic          csn;
    logic [3:0]    io_i;
    logic [3:0]    io_o;
    logic [3:0]    io_oe;
    logic          wr_valid;
    logic [AB-1:0] wr_addr;
    logic [7:0]    wr_data;

    always #5 clock = ~clock;

    qspi_target_mem #(.ADDR_BITS(AB), .DUMMY_CYCLES(DC)) dut (
        .clock    (clock),
        .reset    (reset),
        .sck      (sck),
        .csn      (csn),
        .io_i     (io_i),
        .io_o     (io_o),
        .io_oe    (io_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // write monitor: logs every committed byte and counts pulses longer than one cycle
    logic [11:0] wlog [$];
    logic        wr_prev = 1'b0;
    int          double_cnt = 0;
    always @(negedge clock) begin
        if (wr_valid) wlog.push_back({wr_addr, wr_data});
        if (wr_valid && wr_prev) double_cnt <= double_cnt + 1;
        wr_prev <= wr_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // one sck period: drive io while low, sample DUT just before rising edge
    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] s, output logic [3:0] oe);
        io_i = d;
        wait_clk(HALF);
        s  = io_o;
        oe = io_oe;
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic start_cs();
        csn = 1'b0;
        wait_clk(4);
    endtask

    task automatic stop_cs();
        wait_clk(HALF);
        csn = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] s, oe;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, s, oe);
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr, input bit is_read,
                        input bit quad, input int n, input logic [2:0][7:0] wd,
                        output logic [2:0][7:0] rd, output logic [3:0] oe_data,
                        output logic [3:0] oe_dummy);
        logic [3:0] s, oe;
        logic [7:0] b;
        rd = '0;
        oe_data = 4'b0;
        oe_dummy = 4'b0;
        b = 8'h00;
        start_cs();
        send_byte(cmd);
        send_byte(addr);
        if (is_read && quad) begin
            repeat (DC) begin
                sck_cycle(4'h0, s, oe);
                oe_dummy |= oe;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (!is_read) begin
                if (quad) begin
                    sck_cycle(wd[k][7:4], s, oe);
                    sck_cycle(wd[k][3:0], s, oe);
                end else begin
                    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, wd[k][i]}, s, oe);
                end
            end else begin
                if (quad) begin
                    for (int i = 0; i < 2; i++) begin
                        sck_cycle(4'h0, s, oe);
                        b = {b[3:0], s};
                        oe_data |= oe;
                    end
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        sck_cycle(4'h0, s, oe);
                        b = {b[6:0], s[1]};
                        oe_data |= oe;
                    end
                end
                rd[k] = b;
            end
        end
        stop_cs();
    endtask

    typedef struct {
        logic [7:0]      cmd;
        logic [7:0]      addr;
        bit              rd;
        bit              quad;
        int              n;
        logic [2:0][7:0] data;
        int              nexp;
        logic [2:0][3:0] eaddr;
        logic [2:0][7:0] edata;
        logic [3:0]      eoe;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] cmd, input logic [7:0] addr, input bit rd,
                                 input bit quad, input int n, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic [7:0] d2, input int nexp,
                                 input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                 input logic [3:0] eoe);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.rd = rd; v.quad = quad; v.n = n;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
        v.nexp = nexp;
        v.eaddr[0] = a0; v.eaddr[1] = a1; v.eaddr[2] = a2;
        v.edata[0] = e0; v.edata[1] = e1; v.edata[2] = e2;
        v.eoe = eoe;
        return v;
    endfunction

    initial begin
        vec_t            tbl [8];
        logic [2:0][7:0] rd;
        logic [3:0]      oe_d, oe_m, s, oe, oe_or;
        logic [2:0]      bits;

        // writes: nexp/eaddr/edata describe the wr_valid log; reads: edata/eoe the returned data
        tbl[0] = mkv(8'h02, 8'h05, 0, 0, 1, 8'hA5, 8'h00, 8'h00, 1, 4'h5, 4'h0, 4'h0,
                     8'hA5, 8'h00, 8'h00, 4'b0000);
        tbl[1] = mkv(8'h03, 8'h05, 1, 0, 1, 8'h00, 8'h00, 8'h00, 0, 4'h0, 4'h0, 4'h0,
                     8'hA5, 8'h00, 8'h00, 4'b0010);
        tbl[2] = mkv(8'h32, 8'h0E, 0, 1, 3, 8'h11, 8'h22, 8'h33, QE ? 3 : 0, 4'hE, 4'hF, 4'h0,
                     8'h11, 8'h22, 8'h33, 4'b0000);
        tbl[3] = mkv(8'h6B, 8'h0F, 1, 1, 2, 8'h00, 8'h00, 8'h00, 0, 4'h0, 4'h0, 4'h0,
                     QE ? 8'h22 : 8'h00, QE ? 8'h33 : 8'h00, 8'h00, QE ? 4'b1111 : 4'b0000);
        tbl[4] = mkv(8'h03, 8'h1F, 1, 0, 2, 8'h00, 8'h00, 8'h00, 0, 4'h0, 4'h0, 4'h0,
                     QE ? 8'h22 : 8'h00, QE ? 8'h33 : 8'h00, 8'h00, 4'b0010);
        tbl[5] = mkv(8'h02, 8'h07, 0, 0, 2, 8'h3C, 8'hC3, 8'h00, 2, 4'h7, 4'h8, 4'h0,
                     8'h3C, 8'hC3, 8'h00, 4'b0000);
        tbl[6] = mkv(8'h6B, 8'h07, 1, 1, 2, 8'h00, 8'h00, 8'h00, 0, 4'h0, 4'h0, 4'h0,
                     QE ? 8'h3C : 8'h00, QE ? 8'hC3 : 8'h00, 8'h00, QE ? 4'b1111 : 4'b0000);
        tbl[7] = mkv(8'h03, 8'h08, 1, 0, 1, 8'h00, 8'h00, 8'h00, 0, 4'h0, 4'h0, 4'h0,
                     8'hC3, 8'h00, 8'h00, 4'b0010);

        reset = 1'b1;
        sck   = 1'b0;
        csn   = 1'b1;
        io_i  = 4'h0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(4);
        chk("reset io_o", 32'(io_o), 32'h0);
        chk("reset io_oe", 32'(io_oe), 32'h0);
        chk("reset wr_valid", 32'(wr_valid), 32'h0);
        chk("reset wr_addr", 32'(wr_addr), 32'h0);
        chk("reset wr_data", 32'(wr_data), 32'h0);

        for (int t = 0; t < 8; t++) begin
            wlog.delete();
            xfer(tbl[t].cmd, tbl[t].addr, tbl[t].rd, tbl[t].quad, tbl[t].n, tbl[t].data,
                 rd, oe_d, oe_m);
            if (!tbl[t].rd) begin
                chk($sformatf("vec%0d write count", t), 32'(wlog.size()), 32'(tbl[t].nexp));
                for (int j = 0; j < tbl[t].nexp; j++) begin
                    if (wlog.size() > j) begin
                        chk($sformatf("vec%0d wr_addr[%0d]", t, j), 32'(wlog[j][11:8]),
                            32'(tbl[t].eaddr[j]));
                        chk($sformatf("vec%0d wr_data[%0d]", t, j), 32'(wlog[j][7:0]),
                            32'(tbl[t].edata[j]));
                    end
                end
            end else begin
                for (int j = 0; j < tbl[t].n; j++)
                    chk($sformatf("vec%0d read[%0d]", t, j), 32'(rd[j]), 32'(tbl[t].edata[j]));
                chk($sformatf("vec%0d io_oe data", t), 32'(oe_d), 32'(tbl[t].eoe));
                if (tbl[t].quad)
                    chk($sformatf("vec%0d io_oe dummy", t), 32'(oe_m), 32'h0);
                chk($sformatf("vec%0d read no write", t), 32'(wlog.size()), 32'h0);
            end
        end

        // unknown command followed by 16 cycles of all-ones
        wlog.delete();
        oe_or = 4'b0;
        start_cs();
        send_byte(8'h9F);
        repeat (16) begin
            sck_cycle(4'hF, s, oe);
            oe_or |= oe;
        end
        stop_cs();
        chk("unknown cmd no write", 32'(wlog.size()), 32'h0);
        chk("unknown cmd io_oe", 32'(oe_or), 32'h0);
        xfer(8'h03, 8'h05, 1, 0, 1, '0, rd, oe_d, oe_m);
        chk("after unknown read", 32'(rd[0]), 32'hA5);

        // csn raised after 4 data bits of a single write
        wlog.delete();
        start_cs();
        send_byte(8'h02);
        send_byte(8'h05);
        for (int i = 0; i < 4; i++) sck_cycle(4'h1, s, oe);
        stop_cs();
        chk("partial byte no commit", 32'(wlog.size()), 32'h0);
        xfer(8'h03, 8'h05, 1, 0, 1, '0, rd, oe_d, oe_m);
        chk("partial byte mem kept", 32'(rd[0]), 32'hA5);

        // reset pulsed in the middle of a single read
        start_cs();
        send_byte(8'h03);
        send_byte(8'h05);
        bits = 3'b0;
        oe_or = 4'b0;
        for (int i = 0; i < 3; i++) begin
            sck_cycle(4'h0, s, oe);
            bits = {bits[1:0], s[1]};
            oe_or |= oe;
        end
        chk("pre-reset read bits", 32'(bits), 32'h5);
        chk("pre-reset io_oe", 32'(oe_or), 32'h2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("reset io_oe next clock", 32'(io_oe), 32'h0);
        reset = 1'b0;
        wlog.delete();
        oe_or = 4'b0;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'h1, s, oe);
            oe_or |= oe;
        end
        chk("post-reset csn low stays idle oe", 32'(oe_or), 32'h0);
        chk("post-reset csn low no write", 32'(wlog.size()), 32'h0);
        stop_cs();
        xfer(8'h03, 8'h05, 1, 0, 1, '0, rd, oe_d, oe_m);
        chk("reread after reset", 32'(rd[0]), 32'h00);
        chk("reread after reset io_oe", 32'(oe_d), 32'h2);

        chk("wr_valid one cycle", 32'(double_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
